// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key scheduler: expands the cipher key forward to round 10, then emits round keys 10..0.
// Optional end-of-walk self-check against the loaded key: define AES_INV_KEY_SELFCHECK_EN.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic         busy,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done,
    output logic         key_err
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_EMIT} state_t;

    state_t       r_state;
    logic [127:0] r_w;
    logic [3:0]   r_rnd;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_a, w_b, w_c, w_d;
    logic [31:0]  w_d_inv, w_sb_in, w_rot, w_sub, w_t;
    logic [31:0]  w_fa, w_fb, w_fc, w_fd;
    logic [3:0]   w_rc_idx;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_a = r_w[127:96];
    assign w_b = r_w[95:64];
    assign w_c = r_w[63:32];
    assign w_d = r_w[31:0];

    // One S-box word serves both directions: forward feeds d, reverse feeds the recovered d' = d ^ c
    assign w_d_inv  = w_d ^ w_c;
    assign w_sb_in  = (r_state == S_EMIT) ? w_d_inv : w_d;
    assign w_rc_idx = (r_state == S_EMIT) ? r_rnd : r_rnd + 4'd1;
    assign w_rot    = {w_sb_in[23:0], w_sb_in[31:24]};
    assign w_sub    = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
    assign w_t      = w_sub ^ {rcon(w_rc_idx), 24'h000000};

    assign w_fa = w_a ^ w_t;
    assign w_fb = w_b ^ w_fa;
    assign w_fc = w_c ^ w_fb;
    assign w_fd = w_d ^ w_fc;

`ifdef AES_INV_KEY_SELFCHECK_EN
    logic [127:0] r_ref;
    logic         r_key_err;
    assign key_err = r_key_err;
`else
    assign key_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_rnd   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef AES_INV_KEY_SELFCHECK_EN
            r_ref     <= '0;
            r_key_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w     <= key_in;
                        r_rnd   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_EXPAND;
`ifdef AES_INV_KEY_SELFCHECK_EN
                        r_ref     <= key_in;
                        r_key_err <= 1'b0;
`endif
                    end
                end
                S_EXPAND: begin
                    r_w   <= {w_fa, w_fb, w_fc, w_fd};
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == 4'd9) begin
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_rnd != 4'd0) begin
                            r_w   <= {w_a ^ w_t, w_b ^ w_a, w_c ^ w_b, w_d_inv};
                            r_rnd <= r_rnd - 4'd1;
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
`ifdef AES_INV_KEY_SELFCHECK_EN
                            if (r_w != r_ref) r_key_err <= 1'b1;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_key   = r_w;
    assign out_round = r_rnd;
    assign out_valid = r_valid;
    assign done      = r_done;

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Iterative AES-128 key scheduler for the decryption datapath. It takes the cipher key and expands it forward to round key 10. It then walks the schedule backwards and delivers round keys 10, 9, …, 0 to the inverse-round logic, one key per handshake. This is the order in which the decryption round engine consumes them through its add-round-key stage.

## Interface
- No parameters; fixed to AES-128 (Nk=4, Nr=10).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key. Byte 0 is in bits [127:120] (FIPS-197 order). Sampled only when start is accepted.
- start  input  1  load key_in and begin. Accepted only when busy=0.
- busy  output  1  high from the start-acceptance edge until the final key transfer completes.
- out_key  output  128  current round key (registered).
- out_round  output  4  index of out_key, 10 down to 0.
- out_valid  output  1  out_key/out_round are valid.
- out_ready  input  1  consumer accepts the key this cycle.
- done  output  1  one-cycle pulse after round key 0 is transferred.
- key_err  output  1  self-check failure flag (see Configuration).

## Operation
- States: IDLE, EXPAND, EMIT.
- IDLE:
  - On start=1, latch key_in into the working register W and into the reference register, set rnd=0, go to EXPAND.
  - start while busy=1 is ignored.
- EXPAND runs one round per cycle, with W = (a,b,c,d) as 32-bit words and rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 placed in the top byte:
  - a' = a ^ SubWord(RotWord(d)) ^ rcon[rnd+1]
  - b' = b ^ a'
  - c' = c ^ b'
  - d' = d ^ c'
  - rnd increments each cycle.
  - When rnd becomes 10, go to EMIT.
- EMIT: out_key=W, out_round=rnd, out_valid=1. On out_valid&&out_ready with rnd>0, apply the inverse step:
  - d' = d ^ c
  - c' = c ^ b
  - b' = b ^ a
  - a' = a ^ SubWord(RotWord(d')) ^ rcon[rnd]
  - rnd decrements.
- On handshake with rnd=0: go to IDLE, clear out_valid and busy, pulse done.
- SubWord uses a forward S-box lookup internal to this block, 4 instances. The same S-box serves both directions.
- out_ready with out_valid=0 has no effect. out_valid never drops while waiting for ready in EMIT.

## Timing
- Reset values: out_key=0, out_round=0, out_valid=0, busy=0, done=0, key_err=0. State returns to IDLE.
- Start accepted at edge E0: busy=1 after E0. Round key k is in W after edge Ek. out_valid=1 and out_round=10 after E10.
- Latency from start edge to first valid key: 10 cycles.
- Back-to-back transfers: with out_ready held high, one key per cycle. 11 keys take 11 cycles. done is high in the cycle after the rnd=0 transfer.
- A new start is accepted in the cycle done is high, at the earliest.
- rst mid-EXPAND or mid-EMIT aborts immediately. No done pulse; all outputs take reset values on the next cycle.
- start and the final handshake in the same cycle: start is ignored because busy=1.

## Configuration
- AES_INV_KEY_SELFCHECK_EN defined:
  - At the rnd=0 handshake, compare W against the reference register.
  - On mismatch, set key_err=1. It stays set until the next accepted start or rst.
- AES_INV_KEY_SELFCHECK_EN undefined:
  - The reference register and comparator are omitted.
  - key_err is tied 0.

## Test plan
- Forward expansion: key_in=2b7e151628aed2a6abf7158809cf4f3c, start -> 10 cycles later out_valid=1, out_round=10, out_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Full reverse walk, out_ready=1 continuously:
  - out_round=9: out_key=ac7766f319fadc2128d12941575c006e.
  - out_round=1: out_key=a0fafe1788542cb123a339392a6c7605.
  - out_round=0: out_key=2b7e151628aed2a6abf7158809cf4f3c.
  - Then done pulses once; key_err=0.
- Backpressure: out_ready low for 5 cycles at out_round=7 -> out_key/out_round held stable, no skip or repeat, same sequence as above.
- Start while busy: pulse start with key_in=000102030405060708090a0b0c0d0e0f mid-EXPAND -> ignored, original key's schedule delivered.
- Reset mid-EMIT at out_round=4 -> all outputs 0 next cycle. A new start with key_in=000102030405060708090a0b0c0d0e0f then yields out_round=10, out_key=13111d7fe3944a17f307a78b4d2b30c5.
- Self-check (macro defined): force an internal W corruption via the bench during EMIT -> key_err=1 after the rnd=0 transfer; cleared on the next start. With the macro undefined, the same stimulus leaves key_err=0.
